// File: rtl/agdc.sv
// Garage door controller: three-state Moore FSM driving mutually exclusive
// up/down motor enables from an Activate request and two end-of-travel limits.
module agdc (
    input  logic clk,
    input  logic rst,
    input  logic Activate,
    input  logic UP_Max,
    input  logic DN_Max,
    output logic UP_M,
    output logic DN_M
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        MV_UP = 2'b01,
        MV_DN = 2'b10
    } state_e;

    state_e state_q;
    state_e state_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // With both limits high the sensors disagree, so the door is never driven.
    always_comb begin
        state_d = IDLE;
        unique case (state_q)
            IDLE: begin
                if (Activate && UP_Max && !DN_Max) begin
                    state_d = MV_DN;
                end else if (Activate && !UP_Max) begin
                    state_d = MV_UP;
                end else begin
                    state_d = IDLE;
                end
            end
            MV_UP:   state_d = UP_Max ? IDLE : MV_UP;
            MV_DN:   state_d = DN_Max ? IDLE : MV_DN;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        UP_M = 1'b0;
        DN_M = 1'b0;
        case (state_q)
            MV_UP:   UP_M = 1'b1;
            MV_DN:   DN_M = 1'b1;
            default: begin
                UP_M = 1'b0;
                DN_M = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_agdc.sv
// Bench for agdc: directed scenarios with literal expectations, then random
// traffic checked against a signed-direction door model.
module tb_agdc;

    logic clk;
    logic rst;
    logic Activate;
    logic UP_Max;
    logic DN_Max;
    logic UP_M;
    logic DN_M;

    int unsigned n_checks;
    int unsigned n_pass;
    int          door_dir;

    agdc dut (
        .clk      (clk),
        .rst      (rst),
        .Activate (Activate),
        .UP_Max   (UP_Max),
        .DN_Max   (DN_Max),
        .UP_M     (UP_M),
        .DN_M     (DN_M)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    // Door motion: +1 opening, -1 closing, 0 stopped.
    function automatic int next_dir(int dir, logic r, logic act, logic up, logic dn);
        if (!r)                  return 0;
        if (dir == 1)            return up ? 0 : 1;
        if (dir == -1)           return dn ? 0 : -1;
        if (!act)                return 0;
        if (up && dn)            return 0;
        if (up)                  return -1;
        return 1;
    endfunction

    function automatic logic [1:0] dir_to_motor(int dir);
        if (dir == 1)  return 2'b10;
        if (dir == -1) return 2'b01;
        return 2'b00;
    endfunction

    task automatic drive(input logic r, input logic act, input logic up, input logic dn);
        rst      = r;
        Activate = act;
        UP_Max   = up;
        DN_Max   = dn;
        @(posedge clk);
        door_dir = next_dir(door_dir, r, act, up, dn);
        @(negedge clk);
    endtask

    task automatic dstep(input string tag, input logic r, input logic act,
                         input logic up, input logic dn, input logic [1:0] exp);
        drive(r, act, up, dn);
        check(tag, {UP_M, DN_M}, exp);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        door_dir = 0;
        rst      = 1'b0;
        Activate = 1'b1;
        UP_Max   = 1'b1;
        DN_Max   = 1'b1;
        @(negedge clk);

        dstep("reset",        1'b0, 1'b1, 1'b1, 1'b1, 2'b00);
        dstep("idle_after",   1'b1, 1'b0, 1'b0, 1'b1, 2'b00);

        dstep("open_start",   1'b1, 1'b1, 1'b0, 1'b1, 2'b10);
        dstep("open_hold1",   1'b1, 1'b0, 1'b0, 1'b0, 2'b10);
        dstep("open_hold2",   1'b1, 1'b0, 1'b0, 1'b0, 2'b10);
        dstep("open_limit",   1'b1, 1'b0, 1'b1, 1'b0, 2'b00);

        dstep("close_start",  1'b1, 1'b1, 1'b1, 1'b0, 2'b01);
        dstep("close_hold1",  1'b1, 1'b0, 1'b0, 1'b0, 2'b01);
        dstep("close_hold2",  1'b1, 1'b0, 1'b0, 1'b0, 2'b01);
        dstep("close_limit",  1'b1, 1'b0, 1'b0, 1'b1, 2'b00);

        dstep("fault_noact",  1'b1, 1'b0, 1'b1, 1'b1, 2'b00);
        dstep("fault_act1",   1'b1, 1'b1, 1'b1, 1'b1, 2'b00);
        dstep("fault_act2",   1'b1, 1'b1, 1'b1, 1'b1, 2'b00);

        dstep("mid_start",    1'b1, 1'b1, 1'b0, 1'b0, 2'b10);
        dstep("act_in_up",    1'b1, 1'b1, 1'b0, 1'b0, 2'b10);
        dstep("dnlim_in_up",  1'b1, 1'b0, 1'b0, 1'b1, 2'b10);
        dstep("up_lim_held",  1'b1, 1'b1, 1'b1, 1'b0, 2'b00);
        dstep("level_rearm",  1'b1, 1'b1, 1'b1, 1'b0, 2'b01);
        dstep("act_in_dn",    1'b1, 1'b1, 1'b0, 1'b0, 2'b01);
        dstep("uplim_in_dn",  1'b1, 1'b0, 1'b1, 1'b0, 2'b01);

        dstep("rst_mid_dn",   1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        dstep("post_rst1",    1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
        dstep("post_rst2",    1'b1, 1'b0, 1'b0, 1'b0, 2'b00);

        for (int i = 0; i < 600; i++) begin
            logic r, act, up, dn;
            r   = ($urandom_range(31) != 0);
            act = ($urandom_range(3) == 0);
            up  = ($urandom_range(4) == 0);
            dn  = ($urandom_range(4) == 0);
            drive(r, act, up, dn);
            check("rand_motor", {UP_M, DN_M}, dir_to_motor(door_dir));
            check("rand_excl", {1'b0, UP_M & DN_M}, 2'b00);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
